// File: rtl/seq_cla16_pkg.sv
// Shared definitions for the nibble-serial 16-bit carry-lookahead adder.
//   state_t : controller states (IDLE, RUN, DONE)
//   WIDTH   : operand width in bits
//   NIBBLES : number of 4-bit slices processed per operation
package seq_cla16_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice.
//   a, b : 4-bit operands
//   cin  : carry-in
//   sum  : 4-bit sum
//   cout : carry out of the slice
//   g, p : slice group generate / propagate (independent of cin)
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       g,
  output logic       p
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  always_comb begin
    w_g = a & b;
    w_p = a ^ b;

    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);

    g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
      | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    p = &w_p;

    sum  = w_p ^ w_c;
    cout = g | (p & cin);
  end

endmodule

// File: rtl/seq_cla16.sv
// Nibble-serial 16-bit adder/subtractor built around one reused cla4 slice.
//   Clk, Reset : clock, synchronous active-high reset
//   Start      : request, sampled while not Busy
//   A, B       : 16-bit operands, captured on accept
//   Cin        : carry-in (ignored when Sub=1)
//   Sub        : 0 = A+B+Cin, 1 = A-B
//   Busy       : high while nibbles are being processed
//   Done       : one-cycle pulse, results valid from this cycle
//   Sum, Cout, G, P, Ovf : registered results, held until the next Done
module seq_cla16
  import seq_cla16_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             G,
  output logic             P,
  output logic             Ovf
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_acc;
  logic             r_g;
  logic             r_p;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_gout;
  logic             r_pout;
  logic             r_ovf;

  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_g;
  logic             w_p;
  logic             w_accept;
  logic             w_last;
  logic             w_c15;

  // Operands are shifted right after each nibble, so the slice always
  // sees bits [3:0]; on the last nibble those are the original [15:12].
  cla4 u_cla4 (
    .a    (r_a[3:0]),
    .b    (r_b[3:0]),
    .cin  (r_c),
    .sum  (w_sum),
    .cout (w_cout),
    .g    (w_g),
    .p    (w_p)
  );

  assign w_accept = (r_state != RUN) && Start;
  assign w_last   = (r_state == RUN) && (r_cnt == 2'(NIBBLES - 1));
  // Carry into bit 15 recovered from sum = a ^ b ^ c.
  assign w_c15    = r_a[3] ^ r_b[3] ^ w_sum[3];

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = Start ? RUN : IDLE;
      RUN:     w_next = (r_cnt == 2'(NIBBLES - 1)) ? DONE : RUN;
      DONE:    w_next = Start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_acc  <= '0;
      r_g    <= 1'b0;
      r_p    <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_gout <= 1'b0;
      r_pout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_a   <= A;
      r_b   <= Sub ? ~B : B;
      r_c   <= Sub ? 1'b1 : Cin;
      r_acc <= '0;
      r_g   <= 1'b0;
      r_p   <= 1'b1;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 2'd1;
      r_a   <= {4'b0, r_a[WIDTH-1:4]};
      r_b   <= {4'b0, r_b[WIDTH-1:4]};
      r_c   <= w_cout;
      r_acc <= {w_sum, r_acc[WIDTH-1:4]};
      r_g   <= w_g | (w_p & r_g);
      r_p   <= w_p & r_p;
      if (w_last) begin
        r_sum  <= {w_sum, r_acc[WIDTH-1:4]};
        r_cout <= w_cout;
        r_gout <= w_g | (w_p & r_g);
        r_pout <= w_p & r_p;
        r_ovf  <= w_c15 ^ w_cout;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign Busy = (r_state == RUN);
  assign Done = (r_state == DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign G    = r_gout;
  assign P    = r_pout;
  assign Ovf  = r_ovf;

endmodule
